fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 61 ++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared state encodings and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  function automatic logic isAligned(input logic [1:0] lowBits);
    return lowBits == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Synchronous FIFO holding fetched {pc, instr} pairs, with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST_n,
  input  logic                     iFlush,
  input  logic                     iPush,
  input  logic [WIDTH-1:0]         iPushData,
  input  logic                     iPop,
  output logic                     oValid,
  output logic [WIDTH-1:0]         oHeadData,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_one = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_empty;
  logic             w_full;
  logic             w_doPush;
  logic             w_doPop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = iPush & ~w_full & ~iFlush;
  assign w_doPop  = iPop & ~w_empty & ~iFlush;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (iFlush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + c_one;
      if (w_doPop)  r_rdPtr <= r_rdPtr + c_one;
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= iPushData;
  end

  assign oValid    = ~w_empty;
  assign oHeadData = r_mem[r_rdPtr[AW-1:0]];
  assign oCount    = r_wrPtr - r_rdPtr;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end: PC/FSM, bus requests, prefetch queue.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             XLEN     = 32,
  parameter int             DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic                   iCLK,
  input  logic                   iRST_n,
  output logic                   oIReq,
  output logic [XLEN-1:0]        oIAddr,
  input  logic                   iIAck,
  input  logic [XLEN-1:0]        iIRData,
  input  logic                   iRedirect,
  input  logic [XLEN-1:0]        iRedirectPC,
  output logic                   oValid,
  output logic [XLEN-1:0]        oInstr,
  output logic [XLEN-1:0]        oPC,
  input  logic                   iReady,
  output logic                   oFault,
  output logic [$clog2(DEPTH):0] oCount
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_stateNext;
  logic [XLEN-1:0]   r_fetchPc;
  logic [XLEN-1:0]   w_fetchPcNext;
  logic [XLEN-1:0]   r_iAddr;
  logic              r_iReq;
  logic              r_fault;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_cntNext;
  logic [2*XLEN-1:0] w_head;

  assign w_accept = r_iReq & iIAck;

  always_comb begin
    w_stateNext   = r_state;
    w_fetchPcNext = r_fetchPc;
    w_push        = 1'b0;
    unique case (r_state)
      ST_BOOT: w_stateNext = ST_FETCH;
      default: begin
        if (iRedirect) begin
          w_fetchPcNext = iRedirectPC;
          if (!isAligned(iRedirectPC[1:0]))  w_stateNext = ST_HALT;
          else if (r_iReq && !iIAck)         w_stateNext = ST_DRAIN;
          else                               w_stateNext = ST_FETCH;
        end else if (r_state == ST_FETCH) begin
          if (w_accept) begin
            w_push        = 1'b1;
            w_fetchPcNext = r_fetchPc + XLEN'(INSTR_BYTES);
          end
        end else if (r_state == ST_DRAIN && iIAck) begin
          w_stateNext = ST_FETCH;
        end
      end
    endcase
  end

  // Occupancy one edge ahead so the registered request never outruns the queue.
  assign w_pop     = oValid & iReady & ~iRedirect;
  assign w_cntNext = iRedirect ? '0 : (w_count + CW'(w_push) - CW'(w_pop));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state   <= ST_BOOT;
      r_fetchPc <= RESET_PC;
      r_iReq    <= 1'b0;
      r_iAddr   <= RESET_PC;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_fetchPc <= w_fetchPcNext;
      r_fault   <= (w_stateNext == ST_HALT);
      if (r_iReq && !iIAck) begin
        r_iReq <= 1'b1;
      end else begin
        r_iReq  <= (w_stateNext == ST_FETCH) && (w_cntNext < CW'(DEPTH));
        r_iAddr <= w_fetchPcNext;
      end
    end
  end

  fetch_queue #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iFlush    (iRedirect),
    .iPush     (w_push),
    .iPushData ({r_fetchPc, iIRData}),
    .iPop      (w_pop),
    .oValid    (oValid),
    .oHeadData (w_head),
    .oCount    (w_count)
  );

  assign oIReq  = r_iReq;
  assign oIAddr = r_iAddr;
  assign oFault = r_fault;
  assign oCount = w_count;
  assign oPC    = w_head[2*XLEN-1:XLEN];
  assign oInstr = w_head[XLEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit against a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        oIReq;
  logic [31:0] oIAddr;
  logic        iIAck;
  logic [31:0] iIRData;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        oValid;
  logic [31:0] oInstr;
  logic [31:0] oPC;
  logic        iReady;
  logic        oFault;
  logic [2:0]  oCount;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .iCLK        (clk),
    .iRST_n      (rst_n),
    .oIReq       (oIReq),
    .oIAddr      (oIAddr),
    .iIAck       (iIAck),
    .iIRData     (iIRData),
    .iRedirect   (iRedirect),
    .iRedirectPC (iRedirectPC),
    .oValid      (oValid),
    .oInstr      (oInstr),
    .oPC         (oPC),
    .iReady      (iReady),
    .oFault      (oFault),
    .oCount      (oCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;

  // Reference model: delivered-instruction queue plus bus bookkeeping.
  ent_t        mq[$];
  logic [31:0] mPc;
  logic        mOut;
  logic [31:0] mOutAddr;
  logic        mStale;
  logic        mHalt;
  logic        mRun;

  int busWait  = 0;
  int curWait  = 0;
  int waitCnt  = 0;
  bit busRand  = 0;
  bit spurious = 0;
  int ackCnt   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mPc    = RPC;
    mOut   = 1'b0;
    mStale = 1'b0;
    mHalt  = 1'b0;
    mRun   = 1'b0;
    waitCnt = 0;
  endtask

  task automatic setBus(input int w, input bit rnd, input bit spur);
    busWait  = w;
    curWait  = w;
    busRand  = rnd;
    spurious = spur;
  endtask

  // Called #1 after a rising edge: check outputs, drive inputs, advance one clock.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
    logic        expReq;
    logic        ack;
    logic        pop;
    logic [31:0] expAddr;
    expReq  = mOut || (mRun && !mHalt && (mq.size() < DEPTH));
    expAddr = mOut ? mOutAddr : mPc;
    chk("valid", {63'd0, oValid}, {63'd0, mq.size() != 0});
    chk("count", {61'd0, oCount}, 64'(mq.size()));
    chk("fault", {63'd0, oFault}, {63'd0, mHalt});
    chk("ireq",  {63'd0, oIReq},  {63'd0, expReq});
    if (expReq) chk("iaddr", {32'd0, oIAddr}, {32'd0, expAddr});
    if (mq.size() != 0) begin
      chk("pc",    {32'd0, oPC},    {32'd0, mq[0].pc});
      chk("instr", {32'd0, oInstr}, {32'd0, mq[0].instr});
    end
    ack = 1'b0;
    if (oIReq === 1'b1) begin
      if (waitCnt >= curWait) begin
        ack     = 1'b1;
        waitCnt = 0;
        curWait = busRand ? int'($urandom_range(0, 3)) : busWait;
        ackCnt++;
      end else begin
        waitCnt++;
      end
    end else if (spurious) begin
      ack = ($urandom_range(0, 3) == 0);
    end
    iIAck       = ack;
    iIRData     = ~oIAddr;
    iReady      = rdy;
    iRedirect   = redir;
    iRedirectPC = tgt;
    @(posedge clk);
    pop = rdy && (mq.size() != 0);
    if (redir) begin
      mq.delete();
      mPc   = tgt;
      mHalt = (tgt[1:0] != 2'b00);
      if (expReq && !ack) begin
        mOut     = 1'b1;
        mOutAddr = expAddr;
        mStale   = 1'b1;
      end else begin
        mOut   = 1'b0;
        mStale = 1'b0;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (expReq && ack) begin
        if (!mStale) begin
          mq.push_back({expAddr, ~expAddr});
          mPc = expAddr + 32'd4;
        end
        mOut   = 1'b0;
        mStale = 1'b0;
      end else if (expReq) begin
        mOut     = 1'b1;
        mOutAddr = expAddr;
      end
    end
    mRun = 1'b1;
    #1;
    iRedirect = 1'b0;
    iIAck     = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    rst_n = 1'b0; iIAck = 1'b0; iIRData = '0; iRedirect = 1'b0;
    iRedirectPC = '0; iReady = 1'b1;
    modelReset();
    setBus(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ireq",  {63'd0, oIReq},  64'd0);
    chk("rst_iaddr", {32'd0, oIAddr}, {32'd0, RPC});
    chk("rst_valid", {63'd0, oValid}, 64'd0);
    chk("rst_count", {61'd0, oCount}, 64'd0);
    chk("rst_fault", {63'd0, oFault}, 64'd0);
    rst_n = 1'b1;

    // Zero-wait bus, consumer always ready.
    step(1, 0, 0);
    chk("first_req",  {63'd0, oIReq},  64'd1);
    chk("first_addr", {32'd0, oIAddr}, {32'd0, RPC});
    step(1, 0, 0);
    chk("first_pc",    {32'd0, oPC},    {32'd0, RPC});
    chk("first_instr", {32'd0, oInstr}, 64'h0000_0000_FFBF_FFFF);
    repeat (6) step(1, 0, 0);
    chk("stream_pc", {32'd0, oPC}, {32'd0, RPC + 32'd24});

    // Stalled consumer fills the queue, then drains in order.
    step(1, 1, RPC);
    ackCnt = 0;
    repeat (8) step(0, 0, 0);
    chk("fill_acks",  64'(ackCnt),         64'd4);
    chk("fill_ireq",  {63'd0, oIReq},      64'd0);
    chk("fill_count", {61'd0, oCount},     64'd4);
    step(1, 0, 0);
    chk("resume_count", {61'd0, oCount}, 64'd3);
    chk("resume_ireq",  {63'd0, oIReq},  64'd1);
    repeat (6) step(1, 0, 0);

    // Three wait states, redirect while the request to +8 is pending.
    setBus(3, 0, 0);
    step(1, 1, RPC);
    for (int k = 0; k < 40 && !(oIReq === 1'b1 && oIAddr === RPC + 32'd8); k++) step(1, 0, 0);
    chk("req8_seen", {32'd0, oIAddr}, {32'd0, RPC + 32'd8});
    step(1, 0, 0);
    step(1, 1, RPC + 32'h100);
    chk("drain_hold", {32'd0, oIAddr}, {32'd0, RPC + 32'd8});
    for (int k = 0; k < 40 && oValid !== 1'b1; k++) step(1, 0, 0);
    chk("redir_first_pc", {32'd0, oPC}, {32'd0, RPC + 32'h100});

    // Redirect coinciding with an ack and a pop.
    setBus(0, 0, 0);
    repeat (4) step(1, 0, 0);
    step(1, 1, RPC + 32'h300);
    chk("coinc_valid", {63'd0, oValid}, 64'd0);
    chk("coinc_count", {61'd0, oCount}, 64'd0);
    chk("coinc_addr",  {32'd0, oIAddr}, {32'd0, RPC + 32'h300});

    // Misaligned target halts fetch; an aligned redirect recovers.
    setBus(2, 0, 0);
    repeat (2) step(1, 0, 0);
    step(1, 1, RPC + 32'h102);
    for (int k = 0; k < 10 && oIReq !== 1'b0; k++) step(1, 0, 0);
    repeat (2) step(1, 0, 0);
    chk("halt_fault", {63'd0, oFault}, 64'd1);
    chk("halt_ireq",  {63'd0, oIReq},  64'd0);
    chk("halt_valid", {63'd0, oValid}, 64'd0);
    step(1, 1, RPC + 32'h200);
    chk("recover_fault", {63'd0, oFault}, 64'd0);
    chk("recover_addr",  {32'd0, oIAddr}, {32'd0, RPC + 32'h200});

    // PC wraps past the top of the address space.
    setBus(0, 0, 0);
    repeat (3) step(1, 0, 0);
    step(1, 1, 32'hFFFF_FFFC);
    chk("wrap_addr0", {32'd0, oIAddr}, 64'h0000_0000_FFFF_FFFC);
    step(1, 0, 0);
    chk("wrap_addr1", {32'd0, oIAddr}, 64'd0);
    chk("wrap_pc",    {32'd0, oPC},    64'h0000_0000_FFFF_FFFC);

    // Asynchronous reset while a request is waiting.
    setBus(5, 0, 0);
    repeat (3) step(1, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("areset_ireq",  {63'd0, oIReq},  64'd0);
    chk("areset_count", {61'd0, oCount}, 64'd0);
    chk("areset_addr",  {32'd0, oIAddr}, {32'd0, RPC});
    modelReset();
    setBus(0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 0);
    chk("restart_addr", {32'd0, oIAddr}, {32'd0, RPC});
    repeat (4) step(1, 0, 0);

    // Randomized traffic: random wait states, stalls, redirects, stray acks.
    setBus(0, 1, 1);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        tgt = RPC + 32'($urandom_range(0, 63)) * 32'd4;
        if ($urandom_range(0, 7) == 0) tgt = tgt + 32'd2;
        if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0;
        step($urandom_range(0, 3) != 0, 1, tgt);
      end else begin
        step($urandom_range(0, 3) != 0, 0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
`default_nettype wire
